// File: rtl/quantize_pkg.sv
// Shared widths, saturation value and select-priority decode for the 6-to-4 bit CIM column quantizer.
package quantize_pkg;

  localparam int IN_W  = 6;
  localparam int OUT_W = 4;
  localparam logic [OUT_W-1:0] SAT_VAL = 4'hF;

  // 4to3, 2 and 1 matrices share one mapping, so they collapse into SEL_PASS.
  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_DIV4 = 2'd1,
    SEL_DIV2 = 2'd2,
    SEL_PASS = 2'd3
  } sel_t;

  // Fixed priority: 16to9 > 8to5 > 4to3 > 2 > 1.
  function automatic sel_t decode_sel(
    input logic m16to9,
    input logic m8to5,
    input logic m4to3,
    input logic m2,
    input logic m1
  );
    if (m16to9)                 return SEL_DIV4;
    else if (m8to5)             return SEL_DIV2;
    else if (m4to3 || m2 || m1) return SEL_PASS;
    else                        return SEL_NONE;
  endfunction

endpackage

// File: rtl/quantize_6to4_comb.sv
// Purpose: combinational 6-bit partial sum to 4-bit quantized value, scaled by active matrix count.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; no handshake.
module quantize_6to4_comb
  import quantize_pkg::*;
(
  input  logic [IN_W-1:0]  b6_input,
  input  logic             col_en,
  input  logic             matrix_16to9,
  input  logic             matrix_8to5,
  input  logic             matrix_4to3,
  input  logic             matrix_2,
  input  logic             matrix_1,
  output logic [OUT_W-1:0] q
);

  sel_t sel;

  always_comb begin
    sel = decode_sel(matrix_16to9, matrix_8to5, matrix_4to3, matrix_2, matrix_1);
    q   = '0;
    if (col_en) begin
      unique case (sel)
        SEL_DIV4: q = b6_input[5:2];
        SEL_DIV2: q = b6_input[5] ? SAT_VAL : b6_input[4:1];
        SEL_PASS: q = (b6_input[5:4] != 2'b00) ? SAT_VAL : b6_input[3:0];
        default:  q = '0;
      endcase
    end
  end

endmodule

// File: rtl/quantize_6to4_block.sv
// Purpose: registered 6-to-4 bit column quantizer (combinational map + output flop).
// Latency: 1 cycle from inputs to b4_output; synchronous active-high reset clears it.
// Backpressure: none; a new value is accepted every cycle.
module quantize_6to4_block
  import quantize_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  b6_input,
  input  logic             col_en,
  input  logic             matrix_16to9,
  input  logic             matrix_8to5,
  input  logic             matrix_4to3,
  input  logic             matrix_2,
  input  logic             matrix_1,
  output logic [OUT_W-1:0] b4_output
);

  logic [OUT_W-1:0] q;

  quantize_6to4_comb u_comb (
    .b6_input     (b6_input),
    .col_en       (col_en),
    .matrix_16to9 (matrix_16to9),
    .matrix_8to5  (matrix_8to5),
    .matrix_4to3  (matrix_4to3),
    .matrix_2     (matrix_2),
    .matrix_1     (matrix_1),
    .q            (q)
  );

  always_ff @(posedge clk) begin
    if (rst) b4_output <= '0;
    else     b4_output <= q;
  end

endmodule

// File: tb/tb_quantize_6to4_block.sv
// Directed self-checking bench for quantize_6to4_block.
module tb_quantize_6to4_block;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] b6_input;
  logic       col_en;
  logic       matrix_16to9, matrix_8to5, matrix_4to3, matrix_2, matrix_1;
  logic [3:0] b4_output;

  int errors = 0;
  int checks = 0;

  // Select vector order: {16to9, 8to5, 4to3, 2, 1}
  localparam logic [4:0] S16 = 5'b10000;
  localparam logic [4:0] S8  = 5'b01000;
  localparam logic [4:0] S4  = 5'b00100;
  localparam logic [4:0] S2  = 5'b00010;
  localparam logic [4:0] S1  = 5'b00001;
  localparam logic [4:0] SN  = 5'b00000;

  always #5 clk = ~clk;

  quantize_6to4_block dut (
    .clk          (clk),
    .rst          (rst),
    .b6_input     (b6_input),
    .col_en       (col_en),
    .matrix_16to9 (matrix_16to9),
    .matrix_8to5  (matrix_8to5),
    .matrix_4to3  (matrix_4to3),
    .matrix_2     (matrix_2),
    .matrix_1     (matrix_1),
    .b4_output    (b4_output)
  );

  // Drive inputs on the falling edge, then sample 1 time unit after the next rising edge.
  task automatic cyc(input logic [5:0] x, input logic en, input logic [4:0] sel);
    @(negedge clk);
    b6_input = x;
    col_en   = en;
    {matrix_16to9, matrix_8to5, matrix_4to3, matrix_2, matrix_1} = sel;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1;
    cyc(6'd63, 1'b1, S1);
    checks++;
    if (b4_output !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d expected 0", b4_output);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_col_disable;
    logic [4:0] sels [5] = '{S16, S8, S4, S2, S1};
    for (int i = 0; i < 5; i++) begin
      cyc(6'd63, 1'b0, sels[i]);
      checks++;
      if (b4_output !== 4'd0) begin
        errors++;
        $display("FAIL col_disable sel=%b: got %0d expected 0", sels[i], b4_output);
      end
    end
  endtask

  task automatic test_saturate_max;
    logic [4:0] sels [5] = '{S1, S2, S4, S8, S16};
    for (int i = 0; i < 5; i++) begin
      cyc(6'd63, 1'b1, sels[i]);
      checks++;
      if (b4_output !== 4'd15) begin
        errors++;
        $display("FAIL sat_x63 sel=%b: got %0d expected 15", sels[i], b4_output);
      end
    end
  endtask

  task automatic test_patterns;
    logic [5:0] xs   [8] = '{6'd42, 6'd42, 6'd42, 6'd42, 6'd42, 6'd21, 6'd21, 6'd21};
    logic [4:0] sels [8] = '{S16,   S8,    S4,    S2,    S1,    S16,   S8,    S4};
    logic [3:0] exps [8] = '{4'd10, 4'd15, 4'd15, 4'd15, 4'd15, 4'd5,  4'd10, 4'd15};
    for (int i = 0; i < 8; i++) begin
      cyc(xs[i], 1'b1, sels[i]);
      checks++;
      if (b4_output !== exps[i]) begin
        errors++;
        $display("FAIL pattern x=%0d sel=%b: got %0d expected %0d", xs[i], sels[i], b4_output, exps[i]);
      end
    end
  endtask

  task automatic test_priority;
    logic [5:0] xs   [5] = '{6'd9,  6'd9,      6'd9,  6'd9,      6'd20};
    logic [4:0] sels [5] = '{S1,    S16 | S1,  SN,    S8 | S4,   S4 | S2 | S1};
    logic [3:0] exps [5] = '{4'd9,  4'd2,      4'd0,  4'd4,      4'd15};
    for (int i = 0; i < 5; i++) begin
      cyc(xs[i], 1'b1, sels[i]);
      checks++;
      if (b4_output !== exps[i]) begin
        errors++;
        $display("FAIL priority x=%0d sel=%b: got %0d expected %0d", xs[i], sels[i], b4_output, exps[i]);
      end
    end
  endtask

  // Saturation thresholds and truncation edges, driven back to back.
  task automatic test_back_to_back;
    logic [5:0] xs   [8] = '{6'd15, 6'd16, 6'd31, 6'd32, 6'd30, 6'd3, 6'd7,  6'd60};
    logic [4:0] sels [8] = '{S2,    S2,    S8,    S8,    S8,    S16,  S16,   S16};
    logic [3:0] exps [8] = '{4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd0, 4'd1,  4'd15};
    for (int i = 0; i < 8; i++) begin
      cyc(xs[i], 1'b1, sels[i]);
      checks++;
      if (b4_output !== exps[i]) begin
        errors++;
        $display("FAIL b2b x=%0d sel=%b: got %0d expected %0d", xs[i], sels[i], b4_output, exps[i]);
      end
    end
  endtask

  task automatic test_mid_reset;
    cyc(6'd63, 1'b1, S1);
    checks++;
    if (b4_output !== 4'd15) begin
      errors++;
      $display("FAIL mid_reset_pre: got %0d expected 15", b4_output);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (b4_output !== 4'd0) begin
      errors++;
      $display("FAIL mid_reset_clear: got %0d expected 0", b4_output);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (b4_output !== 4'd15) begin
      errors++;
      $display("FAIL mid_reset_release: got %0d expected 15", b4_output);
    end
  endtask

  // A reset pulse between edges, and an input change, must not touch the output.
  task automatic test_no_async;
    cyc(6'd9, 1'b1, S1);
    @(negedge clk);
    rst      = 1'b1;
    b6_input = 6'd3;
    #2;
    checks++;
    if (b4_output !== 4'd9) begin
      errors++;
      $display("FAIL no_async_effect: got %0d expected 9", b4_output);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (b4_output !== 4'd3) begin
      errors++;
      $display("FAIL after_glitch: got %0d expected 3", b4_output);
    end
  endtask

  initial begin
    rst = 1'b1;
    b6_input = '0;
    col_en = 1'b0;
    {matrix_16to9, matrix_8to5, matrix_4to3, matrix_2, matrix_1} = SN;
    test_reset();
    test_col_disable();
    test_saturate_max();
    test_patterns();
    test_priority();
    test_back_to_back();
    test_mid_reset();
    test_no_async();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/quantize_6to4_block.md
QUANTIZE_6TO4_BLOCK -- requirements
Module: quantize_6to4

Interface
REQ-001 Parameters: none; widths are fixed at 6-bit input and 4-bit output.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 b6_input  input  6  unsigned CIM column partial sum, 0..63.
REQ-005 col_en  input  1  column enable; 1 = quantize, 0 = column disabled.
REQ-006 matrix_16to9  input  1  9 to 16 matrices active.
REQ-007 matrix_8to5  input  1  5 to 8 matrices active.
REQ-008 matrix_4to3  input  1  3 to 4 matrices active.
REQ-009 matrix_2  input  1  exactly 2 matrices active.
REQ-010 matrix_1  input  1  exactly 1 matrix active.
REQ-011 b4_output  output  4  registered unsigned 4-bit quantized value.

Function
REQ-012 Let x = b6_input; the block SHALL compute q combinationally and register it into b4_output on each rising clk edge (latency 1 cycle, no handshake).
REQ-013 col_en=0 SHALL give q=0, regardless of all other inputs.
REQ-014 matrix_16to9 selected: q = x[5:2] (truncating divide by 4, no saturation needed).
REQ-015 matrix_8to5 selected: q = 15 if x[5]=1, else x[4:1] (truncating divide by 2, saturating).
REQ-016 matrix_4to3, matrix_2 or matrix_1 selected: q = 15 if x[5:4]≠0, else x[3:0] (saturating pass-through).
REQ-017 Selects are nominally one-hot. If several are high, priority SHALL be matrix_16to9 > matrix_8to5 > matrix_4to3 > matrix_2 > matrix_1.
REQ-018 No select high with col_en=1: q=0.
REQ-019 Rounding SHALL be truncation (floor); saturation SHALL clamp to 4'hF and never wrap.
REQ-020 No internal state other than the output register.
REQ-021 Input changes SHALL appear at the output at the next rising edge only.

Reset
REQ-022 rst=1 at a rising edge SHALL load b4_output=0, overriding any computed q.
REQ-023 Reset asserted mid-stream SHALL clear the output at that edge.
REQ-024 The first edge after rst deasserts SHALL load the normal q.
REQ-025 rst SHALL have no asynchronous effect.

Structure
REQ-026 The widths IN_W=6 and OUT_W=4 and the saturation value 4'hF SHALL be localparams in a shared package quantize_pkg.
REQ-027 The one-hot priority select decode SHALL be placed in the same shared package.
REQ-028 The combinational mapping SHALL be a sub-module quantize_6to4_comb.
REQ-029 The top level SHALL consist of quantize_6to4_comb plus the output register.

Verification
REQ-030 x=63, col_en=0, each select in turn -> b4_output=0 one cycle later.
REQ-031 x=63, col_en=1, selects 1,2,4to3,8to5,16to9 in turn -> 15,15,15,15,15.
REQ-032 x=42 (101010), col_en=1: 16to9 -> 10; 8to5 -> 15; 4to3/2/1 -> 15.
REQ-033 x=21 (010101), col_en=1: 16to9 -> 5; 8to5 -> 10; 4to3 -> 15.
REQ-034 x=9, matrix_1 -> 9; x=9 with matrix_16to9 and matrix_1 both high -> 2 (priority); no select high -> 0.
REQ-035 Reset check: assert rst while the output is 15 -> 0 at the next edge; deassert rst -> q reappears one edge later.
